// File: rtl/pool_layer_multi.sv
// rtl/pool_layer_multi.sv - 2x2/stride-2 sequential max-pool over K float maps with optional ReLU
module pool_layer_multi #(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 2,
    parameter int H          = 30,
    parameter int W          = 30,
    parameter int RELU       = 1
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic [K*H*W*DATA_WIDTH-1:0]                 inputMaps,
    output logic                                        busy,
    output logic                                        done,
    output logic [K*(H/2)*(W/2)*DATA_WIDTH-1:0]         outputPool
);

    localparam int HO  = H / 2;
    localparam int WO  = W / 2;
    localparam int KW  = (K  > 1) ? $clog2(K)  : 1;
    localparam int IW  = (HO > 1) ? $clog2(HO) : 1;
    localparam int JW  = (WO > 1) ? $clog2(WO) : 1;
    localparam int XBW = $clog2(K * H * W * DATA_WIDTH);
    localparam int OBW = $clog2(K * HO * WO * DATA_WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state;
    logic [1:0]            e;
    logic [JW-1:0]         j;
    logic [IW-1:0]         i;
    logic [KW-1:0]         k;
    logic [DATA_WIDTH-1:0] acc;

    logic [31:0]           in_idx;
    logic [31:0]           out_idx;
    logic [XBW-1:0]        in_bit;
    logic [OBW-1:0]        out_bit;
    logic [DATA_WIDTH-1:0] x;
    logic [DATA_WIDTH-1:0] mx;
    logic [DATA_WIDTH-1:0] res;

    // Sign-magnitude "b strictly greater than a"; +0/-0 compare equal so ties keep a.
    function automatic logic b_gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-2:0] ma;
        logic [DATA_WIDTH-2:0] mb;
        ma = a[DATA_WIDTH-2:0];
        mb = b[DATA_WIDTH-2:0];
        if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
            return !b[DATA_WIDTH-1] && ((ma != '0) || (mb != '0));
        else if (!a[DATA_WIDTH-1])
            return mb > ma;
        else
            return mb < ma;
    endfunction

    always_comb begin
        in_idx  = 32'(k) * 32'(H * W) + (2 * 32'(i) + 32'(e[1])) * 32'(W) + 2 * 32'(j) + 32'(e[0]);
        out_idx = 32'(k) * 32'(HO * WO) + 32'(i) * 32'(WO) + 32'(j);
        in_bit  = XBW'(in_idx * 32'(DATA_WIDTH));
        out_bit = OBW'(out_idx * 32'(DATA_WIDTH));
        x       = inputMaps[in_bit +: DATA_WIDTH];
        mx      = b_gt(acc, x) ? x : acc;
        res     = ((RELU != 0) && mx[DATA_WIDTH-1]) ? '0 : mx;
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            e          <= '0;
            j          <= '0;
            i          <= '0;
            k          <= '0;
            acc        <= '0;
            outputPool <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    e <= '0;
                    j <= '0;
                    i <= '0;
                    k <= '0;
                    if (start)
                        state <= S_RUN;
                end
                S_RUN: begin
                    acc <= (e == 2'd0) ? x : mx;
                    e   <= e + 2'd1;
                    if (e == 2'd3) begin
                        outputPool[out_bit +: DATA_WIDTH] <= res;
                        // Window walk: j fastest, then i, then map k.
                        if (j == JW'(WO - 1)) begin
                            j <= '0;
                            if (i == IW'(HO - 1)) begin
                                i <= '0;
                                if (k == KW'(K - 1)) begin
                                    k     <= '0;
                                    state <= S_DONE;
                                end else begin
                                    k <= k + KW'(1);
                                end
                            end else begin
                                i <= i + IW'(1);
                            end
                        end else begin
                            j <= j + JW'(1);
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_layer_multi.sv
// tb/tb_pool_layer_multi.sv - directed vector bench for pool_layer_multi across three configurations
module tb_pool_layer_multi;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [2:0]   start_v = 3'b000;
    logic [2:0]   busy_v;
    logic [2:0]   done_v;
    logic [511:0] in0 = '0;
    logic [255:0] in1 = '0;
    logic [799:0] in2 = '0;
    logic [127:0] pool0;
    logic [63:0]  pool1;
    logic [127:0] pool2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pool_layer_multi #(.DATA_WIDTH(32), .K(1), .H(4), .W(4), .RELU(0)) dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .inputMaps(in0),
        .busy(busy_v[0]), .done(done_v[0]), .outputPool(pool0));

    pool_layer_multi #(.DATA_WIDTH(32), .K(2), .H(2), .W(2), .RELU(1)) dut1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .inputMaps(in1),
        .busy(busy_v[1]), .done(done_v[1]), .outputPool(pool1));

    pool_layer_multi #(.DATA_WIDTH(32), .K(1), .H(5), .W(5), .RELU(0)) dut2 (
        .clk(clk), .reset(reset), .start(start_v[2]), .inputMaps(in2),
        .busy(busy_v[2]), .done(done_v[2]), .outputPool(pool2));

    // One 2x2 window {e0,e1,e2,e3} (e0 in MSBs) with its expected max without and with ReLU.
    typedef struct packed {
        logic [127:0] w;
        logic [31:0]  exp_lin;
        logic [31:0]  exp_relu;
    } win_t;

    win_t tbl[10];

    function automatic logic [31:0] fp(input int n);
        int          m;
        int          ex;
        logic [31:0] r;
        if (n == 0) return 32'h0;
        m  = (n < 0) ? -n : n;
        ex = 0;
        while ((m >> (ex + 1)) != 0) ex++;
        r[31]    = (n < 0);
        r[30:23] = 8'(127 + ex);
        r[22:0]  = 23'((m << (23 - ex)) & 32'h7FFFFF);
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fill0(input int b);
        for (int w = 0; w < 4; w++)
            for (int e = 0; e < 4; e++)
                in0[(((2 * (w / 2) + e / 2) * 4) + 2 * (w % 2) + e % 2) * 32 +: 32] = tbl[b + w].w[(3 - e) * 32 +: 32];
    endtask

    task automatic fill1(input int b);
        for (int m = 0; m < 2; m++)
            for (int e = 0; e < 4; e++)
                in1[(m * 4 + e) * 32 +: 32] = tbl[b + m].w[(3 - e) * 32 +: 32];
    endtask

    // Issue start, then watch ncyc cycles; poke re-pulses start at RUN cycle 3 and during DONE.
    task automatic run(input int d, input bit poke, input int ncyc,
                       output int nbusy, output int ndone, output int done_at);
        nbusy = 0; ndone = 0; done_at = 0;
        @(posedge clk); #1 start_v[d] = 1'b1;
        @(posedge clk); #1 start_v[d] = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (busy_v[d]) nbusy++;
            if (done_v[d]) begin
                ndone++;
                if (done_at == 0) done_at = c;
            end
            start_v[d] = poke && ((c == 3) || done_v[d]);
        end
        start_v[d] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nb, nd, da, act;

        tbl[0] = {fp(1), fp(2), fp(5), fp(6), fp(6), fp(6)};
        tbl[1] = {fp(3), fp(4), fp(7), fp(8), fp(8), fp(8)};
        tbl[2] = {fp(9), fp(10), fp(13), fp(14), fp(14), fp(14)};
        tbl[3] = {fp(11), fp(12), fp(15), fp(16), fp(16), fp(16)};
        tbl[4] = {fp(-3), fp(-1), fp(-2), fp(-5), 32'hBF800000, 32'h0};
        tbl[5] = {32'h80000000, 32'h0, fp(-1), fp(-2), 32'h80000000, 32'h0};
        tbl[6] = {32'h0, 32'h80000000, fp(-3), fp(-4), 32'h0, 32'h0};
        tbl[7] = {fp(-2), fp(3), fp(-9), fp(1), fp(3), fp(3)};
        tbl[8] = {fp(1), fp(9), fp(3), fp(2), 32'h41100000, 32'h41100000};
        tbl[9] = {fp(4), fp(4), fp(7), fp(-8), 32'h40E00000, 32'h40E00000};

        // Asynchronous reset between edges.
        #3 reset = 1'b1;
        #1;
        chk("reset_busy", 128'(busy_v), 128'(0));
        chk("reset_done", 128'(done_v), 128'(0));
        chk("reset_pool0", pool0, 128'(0));
        chk("reset_pool1", 128'(pool1), 128'(0));
        chk("reset_pool2", pool2, 128'(0));
        #12;
        @(negedge clk) reset = 1'b0;
        act = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (busy_v != 3'b000 || done_v != 3'b000) act++;
        end
        chk("idle_no_activity", 128'(act), 128'(0));

        // 4x4 single map, two vector sets; second run also pokes start in RUN and DONE.
        for (int r = 0; r < 2; r++) begin
            fill0(r * 4);
            run(0, r == 1, 40, nb, nd, da);
            for (int w = 0; w < 4; w++)
                chk($sformatf("pool4x4_run%0d_win%0d", r, w), 128'(pool0[w * 32 +: 32]), 128'(tbl[r * 4 + w].exp_lin));
            chk($sformatf("pool4x4_run%0d_busy_cycles", r), 128'(nb), 128'(16));
            chk($sformatf("pool4x4_run%0d_done_cycle", r), 128'(da), 128'(17));
            chk($sformatf("pool4x4_run%0d_done_count", r), 128'(nd), 128'(1));
        end

        // K=2, 2x2 maps, ReLU enabled.
        for (int r = 0; r < 5; r++) begin
            fill1(r * 2);
            run(1, 1'b0, 20, nb, nd, da);
            for (int m = 0; m < 2; m++)
                chk($sformatf("relu_k2_run%0d_map%0d", r, m), 128'(pool1[m * 32 +: 32]), 128'(tbl[r * 2 + m].exp_relu));
            if (r == 4) begin
                chk("relu_k2_busy_cycles", 128'(nb), 128'(8));
                chk("relu_k2_done_cycle", 128'(da), 128'(9));
            end
        end

        // 5x5 map: row 4 and column 4 must be ignored.
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                in2[(r * 5 + c) * 32 +: 32] = (r == 4 || c == 4) ? 32'h42C80000 : fp(r + c % 2);
        run(2, 1'b0, 40, nb, nd, da);
        chk("odd_win0", 128'(pool2[0 +: 32]), 128'(32'h40000000));
        chk("odd_win1", 128'(pool2[32 +: 32]), 128'(32'h40000000));
        chk("odd_win2", 128'(pool2[64 +: 32]), 128'(32'h40800000));
        chk("odd_win3", 128'(pool2[96 +: 32]), 128'(32'h40800000));
        chk("odd_busy_cycles", 128'(nb), 128'(16));
        chk("odd_done_cycle", 128'(da), 128'(17));

        // Reset during RUN cycle 5: no done, pool cleared, then a clean rerun.
        fill0(0);
        @(posedge clk); #1 start_v[0] = 1'b1;
        @(posedge clk); #1 start_v[0] = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrun_reset_busy", 128'(busy_v[0]), 128'(0));
        chk("midrun_reset_pool", pool0, 128'(0));
        @(negedge clk) reset = 1'b0;
        act = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done_v[0] || busy_v[0]) act++;
        end
        chk("midrun_no_done", 128'(act), 128'(0));
        chk("midrun_pool_stays_zero", pool0, 128'(0));
        run(0, 1'b0, 40, nb, nd, da);
        for (int w = 0; w < 4; w++)
            chk($sformatf("rerun_win%0d", w), 128'(pool0[w * 32 +: 32]), 128'(tbl[w].exp_lin));
        chk("rerun_done_cycle", 128'(da), 128'(17));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
